// File: rtl/qos_rx_demux_pkg.sv
// qos_rx_demux_pkg
//   Constants shared by the receive side of the QoS serial link with the
//   transmit mux and the flow-control FSM.
//   - word geometry: QOS_WORD_W, QOS_NUM_VC, QOS_VC_ID_W
//   - FIFO depth and pause/continue threshold defaults
//   - fifo_op_e: per-cycle FIFO operation used for occupancy bookkeeping
package qos_rx_demux_pkg;

    localparam int unsigned QOS_WORD_W         = 4;
    localparam int unsigned QOS_NUM_VC         = 4;
    localparam int unsigned QOS_VC_ID_W        = 2;

    localparam int unsigned QOS_FIFO_DEPTH_DEF = 4;
    localparam int unsigned QOS_PAUSE_TH_DEF   = 3;
    localparam int unsigned QOS_CONT_TH_DEF    = 1;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage : qos_rx_demux_pkg

// File: rtl/qos_rx_demux_vc_fifo.sv
// rx_vc_fifo
//   One virtual channel of the receive path: serial-to-word deserializer,
//   first-word-fall-through FIFO and occupancy status decode.
//   clk_i, reset_i   clock, synchronous active-high reset
//   bit_valid_i      a serial bit for this VC is present this cycle
//   bit_data_i       serial bit, MSB of each word first
//   rd_en_i          pop request
//   data_o           head word (0 when empty)
//   empty_o/full_o   occupancy == 0 / == FIFO_DEPTH
//   pause_o/cont_o   occupancy >= PAUSE_TH / <= CONT_TH
//   error_o          sticky overflow/underflow flag
//   idle_o           FIFO empty and no partial word in the deserializer
module rx_vc_fifo
    import qos_rx_demux_pkg::*;
#(
    parameter int unsigned WORD_W     = QOS_WORD_W,
    parameter int unsigned FIFO_DEPTH = QOS_FIFO_DEPTH_DEF,
    parameter int unsigned PAUSE_TH   = QOS_PAUSE_TH_DEF,
    parameter int unsigned CONT_TH    = QOS_CONT_TH_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              bit_valid_i,
    input  logic              bit_data_i,
    input  logic              rd_en_i,
    output logic [WORD_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              pause_o,
    output logic              cont_o,
    output logic              error_o,
    output logic              idle_o
);

    localparam int unsigned BIT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] PAUSE_C  = CNT_W'(PAUSE_TH);
    localparam logic [CNT_W-1:0] CONT_C   = CNT_W'(CONT_TH);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];

    logic              word_done;
    logic [WORD_W-1:0] word;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push_ok;
    logic              pop_ok;
    fifo_op_e          op;

    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == DEPTH_C);
    assign word_done  = bit_valid_i && (bit_cnt_q == LAST_BIT);
    assign word       = {shift_q[WORD_W-2:0], bit_data_i};

    // A full FIFO still accepts a completing word when the head is popped on
    // the same edge: the pop frees the slot the write pointer now targets.
    assign pop_ok  = rd_en_i && !fifo_empty;
    assign push_ok = word_done && (!fifo_full || pop_ok);
    assign op      = fifo_op_e'({pop_ok, push_ok});

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        err_d     = err_q;

        if (bit_valid_i) begin
            shift_d   = word;
            bit_cnt_d = word_done ? '0 : bit_cnt_q + BIT_W'(1);
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case (op)
            FIFO_PUSH: occ_d = occ_q + CNT_W'(1);
            FIFO_POP:  occ_d = occ_q - CNT_W'(1);
            default:   occ_d = occ_q;
        endcase

        // Underflow: pop on empty. Overflow: word completes on full, no pop.
        if ((rd_en_i && fifo_empty) || (word_done && !push_ok)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset: entries are only visible while occupancy > 0.
    always_ff @(posedge clk_i) begin
        if (push_ok && !reset_i) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign empty_o = fifo_empty;
    assign full_o  = fifo_full;
    assign pause_o = (occ_q >= PAUSE_C);
    assign cont_o  = (occ_q <= CONT_C);
    assign error_o = err_q;
    assign idle_o  = fifo_empty && (bit_cnt_q == '0);

endmodule : rx_vc_fifo

// File: rtl/qos_rx_demux.sv
// qos_rx_demux
//   Receive end of the QoS serial link. Steers each valid serial bit to the
//   deserializer of its VC, and exposes per-VC FIFO heads and status.
//   clk, reset          clock, synchronous active-high reset
//   valid_in            serial bit valid this cycle
//   vc_id_in, data_in   owning VC and the serial bit (MSB first)
//   rd_en               per-VC pop request
//   data_out            VC i head word at [i*WORD_W +: WORD_W]
//   sEmpty/sFull        per-VC occupancy == 0 / == FIFO_DEPTH
//   sPause/sContinue    per-VC occupancy >= PAUSE_TH / <= CONT_TH
//   rxError             sticky per-VC overflow/underflow
//   rxIdle              all FIFOs empty and no partial words
module qos_rx_demux
    import qos_rx_demux_pkg::*;
#(
    parameter int unsigned WORD_W     = QOS_WORD_W,
    parameter int unsigned FIFO_DEPTH = QOS_FIFO_DEPTH_DEF,
    parameter int unsigned PAUSE_TH   = QOS_PAUSE_TH_DEF,
    parameter int unsigned CONT_TH    = QOS_CONT_TH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_in,
    input  logic [QOS_VC_ID_W-1:0]       vc_id_in,
    input  logic                         data_in,
    input  logic [QOS_NUM_VC-1:0]        rd_en,
    output logic [QOS_NUM_VC*WORD_W-1:0] data_out,
    output logic [QOS_NUM_VC-1:0]        sEmpty,
    output logic [QOS_NUM_VC-1:0]        sFull,
    output logic [QOS_NUM_VC-1:0]        sPause,
    output logic [QOS_NUM_VC-1:0]        sContinue,
    output logic [QOS_NUM_VC-1:0]        rxError,
    output logic                         rxIdle
);

    logic [QOS_NUM_VC-1:0] bit_valid;
    logic [QOS_NUM_VC-1:0] vc_idle;

    for (genvar i = 0; i < QOS_NUM_VC; i++) begin : g_vc
        assign bit_valid[i] = valid_in && (vc_id_in == QOS_VC_ID_W'(i));

        rx_vc_fifo #(
            .WORD_W     (WORD_W),
            .FIFO_DEPTH (FIFO_DEPTH),
            .PAUSE_TH   (PAUSE_TH),
            .CONT_TH    (CONT_TH)
        ) u_vc_fifo (
            .clk_i       (clk),
            .reset_i     (reset),
            .bit_valid_i (bit_valid[i]),
            .bit_data_i  (data_in),
            .rd_en_i     (rd_en[i]),
            .data_o      (data_out[i*WORD_W +: WORD_W]),
            .empty_o     (sEmpty[i]),
            .full_o      (sFull[i]),
            .pause_o     (sPause[i]),
            .cont_o      (sContinue[i]),
            .error_o     (rxError[i]),
            .idle_o      (vc_idle[i])
        );
    end

    assign rxIdle = &vc_idle;

endmodule : qos_rx_demux

// File: tb/tb_qos_rx_demux.sv
// tb_qos_rx_demux
//   Directed stimulus for qos_rx_demux. Words sent are queued per VC as
//   expected FIFO output; a monitor compares each popped head against the
//   queue, while status outputs are checked against hand-computed values.
module tb_qos_rx_demux;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [1:0]  vc_id_in;
    logic        data_in;
    logic [3:0]  rd_en;
    logic [15:0] data_out;
    logic [3:0]  sEmpty;
    logic [3:0]  sFull;
    logic [3:0]  sPause;
    logic [3:0]  sContinue;
    logic [3:0]  rxError;
    logic        rxIdle;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];
    logic [3:0] exp_q2[$];
    logic [3:0] exp_q3[$];

    qos_rx_demux #(
        .WORD_W     (4),
        .FIFO_DEPTH (4),
        .PAUSE_TH   (3),
        .CONT_TH    (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .vc_id_in  (vc_id_in),
        .data_in   (data_in),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .sEmpty    (sEmpty),
        .sFull     (sFull),
        .sPause    (sPause),
        .sContinue (sContinue),
        .rxError   (rxError),
        .rxIdle    (rxIdle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int vc, input logic [3:0] w);
        case (vc)
            0: exp_q0.push_back(w);
            1: exp_q1.push_back(w);
            2: exp_q2.push_back(w);
            default: exp_q3.push_back(w);
        endcase
    endtask

    task automatic clear_exp();
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        exp_q3.delete();
    endtask

    // Monitor: whenever a non-empty VC is popped, its head must match the
    // oldest word sent on that VC.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (rd_en[i] && !sEmpty[i]) begin
                    logic [3:0] exp_w;
                    logic       have;
                    have  = 1'b1;
                    exp_w = '0;
                    case (i)
                        0: if (exp_q0.size() > 0) exp_w = exp_q0.pop_front(); else have = 1'b0;
                        1: if (exp_q1.size() > 0) exp_w = exp_q1.pop_front(); else have = 1'b0;
                        2: if (exp_q2.size() > 0) exp_w = exp_q2.pop_front(); else have = 1'b0;
                        default: if (exp_q3.size() > 0) exp_w = exp_q3.pop_front(); else have = 1'b0;
                    endcase
                    if (!have) begin
                        checks++;
                        failures++;
                        $display("FAIL pop_vc%0d: got %0h expected no word", i, data_out[i*4 +: 4]);
                    end else begin
                        check($sformatf("pop_vc%0d", i), 32'(data_out[i*4 +: 4]), 32'(exp_w));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int vc, input logic b);
        valid_in = 1'b1;
        vc_id_in = 2'(vc);
        data_in  = b;
        tick();
        valid_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic send_word(input int vc, input logic [3:0] w, input logic accepted);
        if (accepted) push_exp(vc, w);
        for (int b = 3; b >= 0; b--) send_bit(vc, w[b]);
    endtask

    task automatic pop(input int vc);
        rd_en[vc] = 1'b1;
        tick();
        rd_en = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        clear_exp();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        vc_id_in = '0;
        data_in  = 1'b0;
        rd_en    = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_sEmpty", 32'(sEmpty), 32'hF);
        check("rst_sContinue", 32'(sContinue), 32'hF);
        check("rst_sFull", 32'(sFull), 32'h0);
        check("rst_sPause", 32'(sPause), 32'h0);
        check("rst_rxError", 32'(rxError), 32'h0);
        check("rst_rxIdle", 32'(rxIdle), 32'h1);
        check("rst_data_out", 32'(data_out), 32'h0);

        // Single word 4'hB on VC2
        send_bit(2, 1'b1);
        send_bit(2, 1'b0);
        check("partial_rxIdle", 32'(rxIdle), 32'h0);
        check("partial_sEmpty", 32'(sEmpty), 32'hF);
        send_bit(2, 1'b1);
        push_exp(2, 4'hB);
        send_bit(2, 1'b1);
        check("single_head", 32'(data_out[11:8]), 32'hB);
        check("single_sEmpty", 32'(sEmpty), 32'hB);
        check("single_rxIdle", 32'(rxIdle), 32'h0);
        pop(2);
        check("single_pop_sEmpty", 32'(sEmpty), 32'hF);
        check("single_pop_rxIdle", 32'(rxIdle), 32'h1);

        // Interleave VC0 4'hA with VC3 4'h5
        begin
            logic [3:0] wa, w5;
            wa = 4'hA;
            w5 = 4'h5;
            push_exp(0, wa);
            push_exp(3, w5);
            for (int b = 3; b >= 0; b--) begin
                send_bit(0, wa[b]);
                send_bit(3, w5[b]);
            end
        end
        check("ilv_vc0", 32'(data_out[3:0]), 32'hA);
        check("ilv_vc3", 32'(data_out[15:12]), 32'h5);
        check("ilv_sEmpty", 32'(sEmpty), 32'h6);
        check("ilv_rxError", 32'(rxError), 32'h0);
        rd_en = 4'b1001;
        tick();
        rd_en = '0;
        check("ilv_pop_sEmpty", 32'(sEmpty), 32'hF);

        // Thresholds, full and overflow on VC1
        send_word(1, 4'h1, 1'b1);
        check("th1_sContinue", 32'(sContinue[1]), 32'h1);
        check("th1_sPause", 32'(sPause[1]), 32'h0);
        send_word(1, 4'h2, 1'b1);
        check("th2_sContinue", 32'(sContinue[1]), 32'h0);
        check("th2_sPause", 32'(sPause[1]), 32'h0);
        send_word(1, 4'h3, 1'b1);
        check("th3_sPause", 32'(sPause[1]), 32'h1);
        check("th3_sFull", 32'(sFull[1]), 32'h0);
        send_word(1, 4'h4, 1'b1);
        check("th4_sFull", 32'(sFull), 32'h2);
        check("th4_rxError", 32'(rxError), 32'h0);
        send_word(1, 4'hF, 1'b0);
        check("ovf_rxError", 32'(rxError), 32'h2);
        check("ovf_sFull", 32'(sFull), 32'h2);
        check("ovf_rxIdle", 32'(rxIdle), 32'h0);
        for (int k = 0; k < 4; k++) pop(1);
        check("ovf_drain_sEmpty", 32'(sEmpty), 32'hF);
        check("ovf_error_sticky", 32'(rxError), 32'h2);

        // Full FIFO with push and pop on the same edge
        do_reset();
        check("rst2_rxError", 32'(rxError), 32'h0);
        for (int k = 1; k <= 4; k++) send_word(1, 4'(k), 1'b1);
        check("fpp_full_before", 32'(sFull), 32'h2);
        push_exp(1, 4'h9);
        send_bit(1, 1'b1);
        send_bit(1, 1'b0);
        send_bit(1, 1'b0);
        rd_en[1] = 1'b1;
        send_bit(1, 1'b1);
        rd_en = '0;
        check("fpp_sFull", 32'(sFull), 32'h2);
        check("fpp_rxError", 32'(rxError), 32'h0);
        check("fpp_head", 32'(data_out[7:4]), 32'h2);
        for (int k = 0; k < 4; k++) pop(1);
        check("fpp_drain_sEmpty", 32'(sEmpty), 32'hF);

        // Underflow and mid-word reset
        pop(0);
        check("udf_rxError", 32'(rxError), 32'h1);
        check("udf_sEmpty", 32'(sEmpty), 32'hF);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        do_reset();
        check("mwr_rxError", 32'(rxError), 32'h0);
        check("mwr_rxIdle", 32'(rxIdle), 32'h1);
        send_word(0, 4'h6, 1'b1);
        check("mwr_head", 32'(data_out[3:0]), 32'h6);
        check("mwr_sEmpty", 32'(sEmpty), 32'hE);
        pop(0);
        check("mwr_pop_sEmpty", 32'(sEmpty), 32'hF);

        check("scoreboard_drained",
              32'(exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_qos_rx_demux
